// File: rtl/pipe_issue.sv
// In-order issue stage: small instruction FIFO feeding a RAW-hazard scoreboard interlock.
// Latency: an instruction pushed into an empty, hazard-free buffer is on out_* one edge later.
// Backpressure: in_ready drops when the buffer is full (registered occupancy only); no output stall.
module pipe_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_LAT   = 3
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_rs1,
    input  logic [3:0] in_rs2,
    input  logic [3:0] in_rd,
    input  logic [1:0] in_func,
    input  logic [7:0] in_addr,
    output logic       out_valid,
    output logic [3:0] out_rs1,
    output logic [3:0] out_rs2,
    output logic [3:0] out_rd,
    output logic [1:0] out_func,
    output logic [7:0] out_addr,
    output logic [7:0] stall_cnt,
    output logic [7:0] issue_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 22;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // Entry layout: {rs1[21:18], rs2[17:14], rd[13:10], func[9:8], addr[7:0]}
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         occ_q, occ_d;
    logic [PIPE_LAT-1:0] sb_vld_q;
    logic [3:0]          sb_rd_q [PIPE_LAT];
    logic [7:0]          stall_cnt_q, stall_cnt_d;
    logic [7:0]          issue_cnt_q, issue_cnt_d;
    logic                out_valid_q;
    logic [EW-1:0]       out_dat_q;

    logic          push, issue, empty, hazard;
    logic [EW-1:0] head;

    assign empty    = (occ_q == '0);
    // Reset gating keeps the upstream from handing us data we would throw away.
    assign in_ready = rst_n && (occ_q < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign issue    = !empty && !hazard;

    // Source-vs-destination match of the head against every in-flight producer.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (sb_vld_q[i] && ((sb_rd_q[i] == head[21:18]) || (sb_rd_q[i] == head[17:14])))
                hazard = 1'b1;
        end
        hazard = hazard && !empty;
    end

    // Next occupancy and counter values.
    always_comb begin
        occ_d = occ_q;
        if (push && !issue)
            occ_d = occ_q + (AW+1)'(1);
        else if (!push && issue)
            occ_d = occ_q - (AW+1)'(1);
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != 8'hFF))
            stall_cnt_d = stall_cnt_q + 8'd1;
        issue_cnt_d = issue ? issue_cnt_q + 8'd1 : issue_cnt_q;
    end

    // Buffer storage; contents are don't-care while invalid, so no reset.
    always_ff @(posedge clk1) begin
        if (push)
            mem_q[wr_ptr_q] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
    end

    // Buffer pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (issue)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            occ_q <= occ_d;
        end
    end

    // Scoreboard shift: slot 0 takes the issued rd or a bubble every edge.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++)
                sb_rd_q[i] <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                sb_vld_q[i] <= sb_vld_q[i-1];
                sb_rd_q[i]  <= sb_rd_q[i-1];
            end
            sb_vld_q[0] <= issue;
            sb_rd_q[0]  <= issue ? head[13:10] : 4'd0;
        end
    end

    // Issue register and statistics counters.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            out_valid_q <= issue;
            out_dat_q   <= issue ? head : '0;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rs1   = out_dat_q[21:18];
    assign out_rs2   = out_dat_q[17:14];
    assign out_rd    = out_dat_q[13:10];
    assign out_func  = out_dat_q[9:8];
    assign out_addr  = out_dat_q[7:0];
    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule
